csla_pipe_adder: RTL and testbench
==================================

Name: csla_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshaking on both sides.
- Uniform-width carry-select groups: each group precomputes its sum for carry-in 0 and carry-in 1, then muxes on the incoming carry.
- Carry and partial results are registered every GROUPS_PER_STAGE groups, so throughput is one operation per cycle at a clock set by the stage depth.
- Datapath arithmetic primitive for address/length computation in the AXI logic; replaces fixed-width combinational adders on timing-critical paths.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP*GROUPS_PER_STAGE.
- GROUP, 8, bits per carry-select group; minimum 2.
- GROUPS_PER_STAGE, 2, groups evaluated combinationally per pipeline stage.
- Derived, not overridable: STAGES = WIDTH/(GROUP*GROUPS_PER_STAGE).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 means no borrow (a >= b unsigned).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset: all stage valid bits, carries and data registers go to 0 immediately. After reset, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Operand preparation on accept: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) handles bit slice [k*S +: S], where S = GROUP*GROUPS_PER_STAGE.
  - The first group of the whole adder is a plain ripple add with c0.
  - Every other group computes both candidate sums/carries and selects with the carry from the previous group.
  - Group carry-out = selected candidate's carry.
- Stage registers hold:
  - valid bit;
  - carry into the next slice;
  - result bits already computed;
  - unprocessed upper bits of a and bb;
  - sign bits a[MSB] and bb[MSB] (needed for ovf).
- Final outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB]==bb[MSB]) && (sum[MSB]!=a[MSB]).
- Latency: a result is presented STAGES cycles after its input transfer. Default: 2 cycles.
- Flow control (bubble-collapsing pipeline):
  - Stage k loads when it is empty or its contents advance this cycle.
  - The last stage advances on an output transfer.
  - in_ready = !v[0] || advance[0], and is combinational from out_ready through the valid chain.
- Backpressure: with out_ready held low, exactly STAGES operations are held; in_ready then drops to 0. No result is lost, duplicated or reordered.
- Output stability: while out_valid && !out_ready, sum/cout/ovf hold stable.
- Simultaneous accept and emit in one cycle is legal at full occupancy and sustains one operation per cycle.
- in_valid with in_ready=0: no state change; the source must hold its operands.
- Reset mid-operation: all in-flight operations are discarded. No out_valid pulse occurs for them after reset release.
- Wrap-around: sums are modulo 2^WIDTH; the carry goes to cout only.

Test Plan:
- Defaults, add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> 2 cycles later sum=0x00000000, cout=1, ovf=0. Also a=0x0000FFFF, b=0x00000000, cin=1 -> sum=0x00010000 (carry crosses group and stage boundary).
- Add overflow: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Subtract, sub=1, cin=1 (ignored): 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0. 0x80000000-1 -> sum=0x7FFFFFFF, cout=1, ovf=1. 9-9 -> sum=0, cout=1.
- Backpressure: 4 back-to-back ops 1+1, 2+2, 3+3, 4+4 with out_ready=0 for the first 4 cycles -> in_ready drops after 2 accepts. Results 2,4,6,8 emerge in order with no gaps once out_ready=1, each held stable while stalled.
- Throughput: 16 consecutive ops with out_ready=1 -> out_valid continuous for 16 cycles starting 2 cycles after the first accept. Every result matches a reference model.
- Reset mid-operation: 2 ops in flight, assert rst for 1 cycle -> out_valid=0 and sum=0 immediately. No stale result after release. A new op 3+4 returns 7 at latency 2.
- Parameter sweep: WIDTH=16/GROUP=4/GPS=1 (4 stages) and WIDTH=64/GROUP=8/GPS=4 (2 stages) -> latency equals STAGES. 10k random add/sub operations with random valid/ready match the model.

Source files
------------

// File: rtl/csla_pipe_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : csla_pipe_adder                                          |
// | Description : Pipelined carry-select adder/subtractor with valid/ready |
// |               handshaking. Each stage resolves GROUPS_PER_STAGE        |
// |               carry-select groups and registers the carry and results. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module csla_pipe_adder #(
    parameter int WIDTH            = 32,
    parameter int GROUP            = 8,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Bits resolved per pipeline stage and resulting pipeline depth.
    localparam int c_S      = GROUP * GROUPS_PER_STAGE;
    localparam int c_STAGES = WIDTH / c_S;
    localparam int c_LAST   = c_STAGES - 1;
    localparam int c_MSB    = WIDTH - 1;

    // Stage registers: valid, carry into the next slice, operands, partial sum.
    logic [c_STAGES-1:0] r_v;
    logic [c_STAGES-1:0] r_c;
    logic [WIDTH-1:0]    r_a   [c_STAGES];
    logic [WIDTH-1:0]    r_b   [c_STAGES];
    logic [WIDTH-1:0]    r_sum [c_STAGES];

    // Per-stage inputs (ports for stage 0, previous register otherwise).
    logic [c_STAGES-1:0] w_src_v;
    logic [c_STAGES-1:0] w_src_c;
    logic [WIDTH-1:0]    w_src_a   [c_STAGES];
    logic [WIDTH-1:0]    w_src_b   [c_STAGES];
    logic [WIDTH-1:0]    w_src_sum [c_STAGES];

    // Per-stage combinational results and load enables.
    logic [WIDTH-1:0]    w_res [c_STAGES];
    logic [c_STAGES-1:0] w_co;
    logic [c_STAGES-1:0] w_load;

    // Select each stage's source: prepared operands for stage 0, upstream register otherwise.
    always_comb begin
        w_src_v[0]   = in_valid;
        w_src_a[0]   = a;
        w_src_b[0]   = sub ? ~b : b;
        w_src_c[0]   = sub ? 1'b1 : cin;
        w_src_sum[0] = '0;
        for (int k = 1; k < c_STAGES; k++) begin
            w_src_v[k]   = r_v[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_c[k]   = r_c[k-1];
            w_src_sum[k] = r_sum[k-1];
        end
    end

    // Carry-select datapath: each group precomputes both carry-in cases and muxes on the live carry.
    always_comb begin
        logic             c;
        logic [GROUP:0]   s0;
        logic [GROUP:0]   s1;
        logic [GROUP:0]   sel;
        logic [GROUP-1:0] ga;
        logic [GROUP-1:0] gb;
        c   = 1'b0;
        s0  = '0;
        s1  = '0;
        sel = '0;
        ga  = '0;
        gb  = '0;
        for (int k = 0; k < c_STAGES; k++) begin
            c        = w_src_c[k];
            w_res[k] = w_src_sum[k];
            for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
                ga = w_src_a[k][k*c_S + g*GROUP +: GROUP];
                gb = w_src_b[k][k*c_S + g*GROUP +: GROUP];
                if (k == 0 && g == 0) begin
                    // Lowest group sees the real carry-in immediately, so a plain ripple add suffices.
                    sel = {1'b0, ga} + {1'b0, gb} + {{GROUP{1'b0}}, c};
                end else begin
                    s0  = {1'b0, ga} + {1'b0, gb};
                    s1  = s0 + (GROUP+1)'(1);
                    sel = c ? s1 : s0;
                end
                w_res[k][k*c_S + g*GROUP +: GROUP] = sel[GROUP-1:0];
                c = sel[GROUP];
            end
            w_co[k] = c;
        end
    end

    // Bubble-collapsing flow control: a stage loads when empty or when its contents move on.
    always_comb begin
        logic down_ready;
        w_load     = '0;
        down_ready = out_ready;
        for (int k = c_LAST; k >= 0; k--) begin
            w_load[k]  = !r_v[k] || down_ready;
            down_ready = w_load[k];
        end
    end

    // Pipeline registers; data only captured for valid entries so held results stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < c_STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else begin
            for (int k = 0; k < c_STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_c[k]   <= w_co[k];
                        r_a[k]   <= w_src_a[k];
                        r_b[k]   <= w_src_b[k];
                        r_sum[k] <= w_res[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[c_LAST];
    assign sum       = r_sum[c_LAST];
    assign cout      = r_c[c_LAST];
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf       = (r_a[c_LAST][c_MSB] == r_b[c_LAST][c_MSB]) &&
                       (r_sum[c_LAST][c_MSB] != r_a[c_LAST][c_MSB]);

endmodule
`default_nettype wire

// File: tb/tb_csla_pipe_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_csla_pipe_adder                                       |
// | Description : Self-checking bench for csla_pipe_adder in three         |
// |               configurations against a plain-arithmetic model.         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_csla_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default configuration: 32/8/2, two stages.
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    // 16/4/1, four stages.
    logic        d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready, d1_cout, d1_ovf;
    logic [15:0] d1_a, d1_b, d1_sum;
    // 64/8/4, two stages.
    logic        d2_in_valid, d2_in_ready, d2_cin, d2_sub, d2_out_valid, d2_out_ready, d2_cout, d2_ovf;
    logic [63:0] d2_a, d2_b, d2_sum;

    csla_pipe_adder #(.WIDTH(32), .GROUP(8), .GROUPS_PER_STAGE(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    csla_pipe_adder #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .a(d1_a), .b(d1_b),
        .cin(d1_cin), .sub(d1_sub), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
    );

    csla_pipe_adder #(.WIDTH(64), .GROUP(8), .GROUPS_PER_STAGE(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a(d2_a), .b(d2_b),
        .cin(d2_cin), .sub(d2_sub), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .sum(d2_sum), .cout(d2_cout), .ovf(d2_ovf)
    );

    // Reference: unsigned and signed arithmetic in wide integers. Returns {ovf, cout, sum[63:0]}.
    function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic s);
        logic [64:0]        u;
        logic [63:0]        mask;
        logic               co;
        logic signed [66:0] sx, sy, r, lim;
        logic               ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            co = u[w];
        end
        sx = $signed({3'b000, x});
        sy = $signed({3'b000, y});
        if (x[w-1]) sx = sx - (67'sd1 <<< w);
        if (y[w-1]) sy = sy - (67'sd1 <<< w);
        r   = s ? (sx - sy) : (sx + sy + (ci ? 67'sd1 : 67'sd0));
        lim = 67'sd1 <<< (w - 1);
        ov  = (r >= lim) || (r < -lim);
        return {ov, co, u[63:0] & mask};
    endfunction

    // Random operand biased toward corner values.
    function automatic logic [63:0] rand_op(input int w);
        logic [63:0] mask, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = mask;
            2: r = 64'd1 << (w - 1);
            3: r = (64'd1 << (w - 1)) - 64'd1;
            default: ;
        endcase
        return r & mask;
    endfunction

    // Single operation on the default DUT: checks acceptance, latency and result.
    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s,
                           input logic [31:0] es, input logic ec, input logic eo, input string nm);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = s; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b expected 1", nm, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat <= 10) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL %s latency: got %0d expected 2", nm, lat);
        end
        checks++;
        if ({sum, cout, ovf} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
        d1_in_valid = 0; d1_a = 0; d1_b = 0; d1_cin = 0; d1_sub = 0; d1_out_ready = 0;
        d2_in_valid = 0; d2_a = 0; d2_b = 0; d2_cin = 0; d2_sub = 0; d2_out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b sum=%h cout=%b ovf=%b in_ready=%b expected 0 0 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        checks++;
        if ({d1_out_valid, d1_in_ready, d2_out_valid, d2_in_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL reset_sweep: got %b%b%b%b expected 0101", d1_out_valid, d1_in_ready, d2_out_valid, d2_in_ready);
        end
    endtask

    task automatic test_add();
        run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        run_one(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, "add_cin_cross");
    endtask

    task automatic test_add_overflow();
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos");
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "ovf_neg");
    endtask

    task automatic test_sub();
        run_one(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7");
        run_one(32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run_one(32'd9, 32'd9, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_equal");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        int          acc = 0, got = 0;
        bit          started = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            if (acc < 4) begin
                in_valid = 1'b1; a = acc + 1; b = acc + 1; cin = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 4) begin
                checks++;
                if (in_ready !== (cyc < 2)) begin
                    errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready, (cyc < 2));
                end
            end
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== 32'd2) begin
                    errors++; $display("FAIL bp_hold cyc%0d: got valid=%b sum=%h expected 1 00000002", cyc, out_valid, sum);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(2 * (acc + 1));
                acc++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got sum=%h expected no result", sum);
                end else begin
                    if (sum !== exp_q[0]) begin
                        errors++; $display("FAIL bp_order: got %h expected %h", sum, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
                started = 1;
            end else if (started && got < 4) begin
                checks++; errors++;
                $display("FAIL bp_gap cyc%0d: got out_valid=%b expected 1", cyc, out_valid);
            end
        end
        checks++;
        if (got != 4) begin
            errors++; $display("FAIL bp_count: got %0d expected 4", got);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_throughput();
        logic [65:0] q[$];
        logic [65:0] act;
        int          sent = 0;
        logic        fresh = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (sent < 16) begin
                in_valid = 1'b1;
                if (fresh) begin
                    a = 32'(rand_op(32)); b = 32'(rand_op(32)); cin = 1'($urandom); sub = 1'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL tp_in_ready cyc%0d: got %b expected 1", cyc, in_ready);
                end
            end
            if (cyc >= 2 && cyc <= 17) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL tp_continuous cyc%0d: got out_valid=%b expected 1", cyc, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                act = {ovf, cout, 32'd0, sum};
                if (q.size() == 0) begin
                    errors++; $display("FAIL tp_extra cyc%0d: got %h expected no result", cyc, act);
                end else begin
                    if (act !== q[0]) begin
                        errors++; $display("FAIL tp_result cyc%0d: got %h expected %h", cyc, act, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            fresh = in_valid && in_ready;
            if (fresh) begin
                q.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
                sent++;
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL tp_leftover: got %0d pending expected 0", q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd6; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 32'd7; b = 32'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'd11) begin
            errors++; $display("FAIL rm_inflight: got valid=%b sum=%h expected 1 0000000b", out_valid, sum);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL rm_async: got valid=%b sum=%h in_ready=%b expected 0 00000000 1", out_valid, sum, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rm_stale cyc%0d: got out_valid=%b expected 0", i, out_valid);
            end
        end
        run_one(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, "rm_new_op");
    endtask

    task automatic test_sweep_latency();
        logic [65:0] e;
        int          lat;
        // 16-bit, four stages
        @(posedge clk); #1;
        d1_in_valid = 1'b1; d1_a = 16'h0FFF; d1_b = 16'h0001; d1_cin = 1'b1; d1_sub = 1'b0; d1_out_ready = 1'b1;
        e = model(16, 64'h0FFF, 64'h0001, 1'b1, 1'b0);
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        lat = 1;
        while (lat <= 12) begin
            @(negedge clk);
            if (d1_out_valid === 1'b1) break;
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL sweep16_latency: got %0d expected 4", lat);
        end
        checks++;
        if ({d1_ovf, d1_cout, 48'd0, d1_sum} !== e) begin
            errors++; $display("FAIL sweep16_result: got %h expected %h", {d1_ovf, d1_cout, 48'd0, d1_sum}, e);
        end
        // 64-bit, two stages
        @(posedge clk); #1;
        d2_in_valid = 1'b1; d2_a = 64'h0000_0000_FFFF_FFFF; d2_b = 64'h1; d2_cin = 1'b0; d2_sub = 1'b0; d2_out_ready = 1'b1;
        e = model(64, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        lat = 1;
        while (lat <= 12) begin
            @(negedge clk);
            if (d2_out_valid === 1'b1) break;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL sweep64_latency: got %0d expected 2", lat);
        end
        checks++;
        if ({d2_ovf, d2_cout, d2_sum} !== e) begin
            errors++; $display("FAIL sweep64_result: got %h expected %h", {d2_ovf, d2_cout, d2_sum}, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_d1(input int n);
        logic [65:0] q[$];
        logic [65:0] act;
        int          sent = 0, got = 0;
        logic        fresh = 1'b1;
        for (int cyc = 0; cyc < n * 8 && got < n; cyc++) begin
            @(posedge clk); #1;
            if (fresh) begin
                d1_in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
                d1_a = 16'(rand_op(16)); d1_b = 16'(rand_op(16));
                d1_cin = 1'($urandom); d1_sub = 1'($urandom);
            end
            d1_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (d1_out_valid && d1_out_ready) begin
                checks++;
                act = {d1_ovf, d1_cout, 48'd0, d1_sum};
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd16_extra: got %h expected no result", act);
                end else begin
                    if (act !== q[0]) begin
                        errors++; $display("FAIL rnd16_result #%0d: got %h expected %h", got, act, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (d1_in_valid && d1_in_ready) begin
                q.push_back(model(16, {48'd0, d1_a}, {48'd0, d1_b}, d1_cin, d1_sub));
                sent++;
                fresh = 1'b1;
            end else begin
                fresh = !d1_in_valid;
            end
        end
        checks++;
        if (got != n) begin
            errors++; $display("FAIL rnd16_count: got %0d expected %0d", got, n);
        end
        d1_in_valid = 1'b0;
    endtask

    task automatic test_random_d2(input int n);
        logic [65:0] q[$];
        logic [65:0] act;
        int          sent = 0, got = 0;
        logic        fresh = 1'b1;
        for (int cyc = 0; cyc < n * 8 && got < n; cyc++) begin
            @(posedge clk); #1;
            if (fresh) begin
                d2_in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
                d2_a = rand_op(64); d2_b = rand_op(64);
                d2_cin = 1'($urandom); d2_sub = 1'($urandom);
            end
            d2_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (d2_out_valid && d2_out_ready) begin
                checks++;
                act = {d2_ovf, d2_cout, d2_sum};
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd64_extra: got %h expected no result", act);
                end else begin
                    if (act !== q[0]) begin
                        errors++; $display("FAIL rnd64_result #%0d: got %h expected %h", got, act, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (d2_in_valid && d2_in_ready) begin
                q.push_back(model(64, d2_a, d2_b, d2_cin, d2_sub));
                sent++;
                fresh = 1'b1;
            end else begin
                fresh = !d2_in_valid;
            end
        end
        checks++;
        if (got != n) begin
            errors++; $display("FAIL rnd64_count: got %0d expected %0d", got, n);
        end
        d2_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_sweep_latency();
        test_random_d1(10000);
        test_random_d2(10000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
